// File: rtl/pulse_train_pkg.sv
// Shared types, defaults and sizing helper for the pulse-train generator.
// Optional abort input is enabled by defining PTG_ABORT_EN.
package pulse_train_pkg;

    localparam int unsigned PtgNumWDefault    = 4;
    localparam int unsigned PtgHighCycDefault = 1;
    localparam int unsigned PtgLowCycDefault  = 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHigh,
        StLow
    } ptg_state_e;

    // Phase counter must hold HIGH_CYC-1 and LOW_CYC-1.
    function automatic int unsigned ptg_ph_width(input int unsigned high_cyc,
                                                 input int unsigned low_cyc);
        int unsigned max_cyc;
        max_cyc = (high_cyc > low_cyc) ? high_cyc : low_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/ptg_phase_cnt.sv
// Loadable down-counter with zero flag; times both HIGH and LOW phases of a pulse.
// Load has priority over decrement; decrement saturates at zero.
module ptg_phase_cnt #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse-train generator: takes numero over a dav_/rfd handshake and emits numero+1 pulses.
// Defining PTG_ABORT_EN adds an abort input that cancels a train in progress.
module pulse_train_gen import pulse_train_pkg::*; #(
    parameter int unsigned NUM_W    = PtgNumWDefault,
    parameter int unsigned HIGH_CYC = PtgHighCycDefault,
    parameter int unsigned LOW_CYC  = PtgLowCycDefault
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dav_,
    input  logic [NUM_W-1:0] numero,
    output logic             rfd,
    output logic             out
`ifdef PTG_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int unsigned PhW = ptg_ph_width(HIGH_CYC, LOW_CYC);
    localparam logic [PhW-1:0] HighLd = PhW'(HIGH_CYC - 1);
    localparam logic [PhW-1:0] LowLd  = PhW'(LOW_CYC - 1);

    if (HIGH_CYC == 0 || LOW_CYC == 0) begin : gen_shape_check
        $error("pulse_train_gen: HIGH_CYC and LOW_CYC must both be >= 1");
    end

    ptg_state_e       state_q, state_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             rfd_q, rfd_d;
    logic             out_q, out_d;

    logic             ph_load;
    logic [PhW-1:0]   ph_load_val;
    logic             ph_dec;
    logic             ph_zero;
    logic             abort_w;

`ifdef PTG_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    ptg_phase_cnt #(
        .Width (PhW)
    ) u_phase_cnt (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_load_val),
        .dec_i      (ph_dec),
        .zero_o     (ph_zero)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        rfd_d       = rfd_q;
        out_d       = out_q;
        ph_load     = 1'b0;
        ph_load_val = HighLd;
        ph_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                rfd_d = 1'b1;
                out_d = 1'b0;
                if (!dav_) begin
                    rem_d   = numero;
                    rfd_d   = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dav_) begin
                    out_d       = 1'b1;
                    ph_load     = 1'b1;
                    ph_load_val = HighLd;
                    state_d     = StHigh;
                end
            end
            StHigh: begin
                if (!ph_zero) begin
                    ph_dec = 1'b1;
                end else begin
                    out_d       = 1'b0;
                    ph_load     = 1'b1;
                    ph_load_val = LowLd;
                    state_d     = StLow;
                end
            end
            StLow: begin
                if (!ph_zero) begin
                    ph_dec = 1'b1;
                end else if (rem_q == '0) begin
                    rfd_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    rem_d       = rem_q - NUM_W'(1);
                    out_d       = 1'b1;
                    ph_load     = 1'b1;
                    ph_load_val = HighLd;
                    state_d     = StHigh;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Cancellation overrides whatever transition was chosen above.
        if (abort_w && (state_q != StIdle)) begin
            state_d = StIdle;
            rem_d   = rem_q;
            out_d   = 1'b0;
            rfd_d   = 1'b1;
            ph_load = 1'b0;
            ph_dec  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            rfd_q   <= 1'b1;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            rfd_q   <= rfd_d;
            out_q   <= out_d;
        end
    end

    assign rfd = rfd_q;
    assign out = out_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: three parameterisations, directed and random trains.
// Expected waveforms come from the train timeline: (numero+1) x (HIGH_CYC ones, LOW_CYC zeros).
module tb_pulse_train_gen;

    logic       clock;
    logic       reset    [3];
    logic       dav_n    [3];
    logic [3:0] numero_s [3];
    logic       rfd_w    [3];
    logic       out_w    [3];
`ifdef PTG_ABORT_EN
    logic       abort_s  [3];
`endif

    int n_pass;
    int n_total;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    pulse_train_gen #(.NUM_W(4), .HIGH_CYC(1), .LOW_CYC(1)) u_dut_a (
        .clock  (clock),
        .reset  (reset[0]),
        .dav_   (dav_n[0]),
        .numero (numero_s[0][3:0]),
        .rfd    (rfd_w[0]),
        .out    (out_w[0])
`ifdef PTG_ABORT_EN
        ,
        .abort  (abort_s[0])
`endif
    );

    pulse_train_gen #(.NUM_W(2), .HIGH_CYC(1), .LOW_CYC(1)) u_dut_b (
        .clock  (clock),
        .reset  (reset[1]),
        .dav_   (dav_n[1]),
        .numero (numero_s[1][1:0]),
        .rfd    (rfd_w[1]),
        .out    (out_w[1])
`ifdef PTG_ABORT_EN
        ,
        .abort  (abort_s[1])
`endif
    );

    pulse_train_gen #(.NUM_W(3), .HIGH_CYC(3), .LOW_CYC(2)) u_dut_c (
        .clock  (clock),
        .reset  (reset[2]),
        .dav_   (dav_n[2]),
        .numero (numero_s[2][2:0]),
        .rfd    (rfd_w[2]),
        .out    (out_w[2])
`ifdef PTG_ABORT_EN
        ,
        .abort  (abort_s[2])
`endif
    );

    function automatic int hc(input int d);
        case (d)
            0:       return 1;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int lc(input int d);
        case (d)
            0:       return 1;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int nw(input int d);
        case (d)
            0:       return 4;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check_eq(input string tag, input int d, input logic [31:0] got,
                            input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", tag, d, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int d, input int k);
        dav_n[d] = 1'b1;
        for (int i = 0; i < k; i++) begin
            tick();
            check_eq("idle_rfd", d, rfd_w[d], 1);
            check_eq("idle_out", d, out_w[d], 0);
        end
    endtask

    // cut_at: train-edge index at which to cancel (-1 = none).
    // cut_kind: 0 reset, 1 abort, 2 reset and abort together.
    task automatic run_train(input int d, input int n, input int stall, input int cut_at,
                             input int cut_kind);
        int per;
        int total;
        per   = hc(d) + lc(d);
        total = (n + 1) * per;

        dav_n[d]    = 1'b0;
        numero_s[d] = 4'(n);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("wait_rfd", d, rfd_w[d], 0);
            check_eq("wait_out", d, out_w[d], 0);
        end
        dav_n[d]    = 1'b1;
        numero_s[d] = 4'($urandom);

        for (int t = 0; t <= total; t++) begin
            if (t == cut_at) begin
                dav_n[d] = 1'b1;
                if (cut_kind != 1) reset[d] = 1'b1;
`ifdef PTG_ABORT_EN
                if (cut_kind != 0) abort_s[d] = 1'b1;
`endif
                tick();
                check_eq("cut_out", d, out_w[d], 0);
                check_eq("cut_rfd", d, rfd_w[d], 1);
                reset[d] = 1'b0;
`ifdef PTG_ABORT_EN
                abort_s[d] = 1'b0;
`endif
                return;
            end
            tick();
            if (t < total) begin
                check_eq("train_out", d, out_w[d], ((t % per) < hc(d)) ? 1 : 0);
                check_eq("train_rfd", d, rfd_w[d], 0);
                // dav_ and numero are don't-cares once the train has started.
                dav_n[d]    = 1'($urandom_range(0, 1));
                numero_s[d] = 4'($urandom);
            end else begin
                check_eq("end_out", d, out_w[d], 0);
                check_eq("end_rfd", d, rfd_w[d], 1);
                dav_n[d] = 1'b1;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int d = 0; d < 3; d++) begin
            reset[d]    = 1'b1;
            dav_n[d]    = 1'b0;
            numero_s[d] = 4'd0;
`ifdef PTG_ABORT_EN
            abort_s[d]  = 1'b0;
`endif
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_rfd", d, rfd_w[d], 1);
            check_eq("rst_out", d, out_w[d], 0);
            reset[d] = 1'b0;
            dav_n[d] = 1'b1;
        end
        for (int d = 0; d < 3; d++) idle_cycles(d, 1);

        // Single pulse, dav_ low for two cycles.
        run_train(0, 0, 2, -1, 0);
        // Full count range on a 2-bit numero.
        run_train(1, 3, 1, -1, 0);
        // Shaped pulses 3 high / 2 low.
        run_train(2, 1, 1, -1, 0);
        // Handshake stall: dav_ held low 10 cycles after capture.
        run_train(0, 2, 11, -1, 0);
        run_train(2, 2, 11, -1, 0);
        // Back-to-back trains with no extra idle cycle.
        run_train(1, 1, 1, -1, 0);
        run_train(1, 2, 1, -1, 0);
        // Reset during the 3rd pulse, then a single-pulse request.
        run_train(0, 5, 1, 5, 0);
        run_train(0, 0, 1, -1, 0);
        run_train(2, 5, 1, 12, 0);
        run_train(2, 0, 1, -1, 0);

`ifdef PTG_ABORT_EN
        // Abort in LOW of pulse 2 of 4, then with reset at the same time.
        for (int k = 1; k <= 2; k++) begin
            for (int d = 0; d < 3; d += 2) begin
                run_train(d, 3, 1, hc(d) + lc(d) + hc(d) + 1, k);
                idle_cycles(d, 4);
            end
        end
        // Abort is ignored in IDLE: the request is still captured.
        abort_s[0]  = 1'b1;
        dav_n[0]    = 1'b0;
        numero_s[0] = 4'd0;
        tick();
        check_eq("idle_abort_rfd", 0, rfd_w[0], 0);
        abort_s[0] = 1'b0;
        dav_n[0]   = 1'b1;
        tick();
        check_eq("idle_abort_out", 0, out_w[0], 1);
        tick();
        check_eq("idle_abort_low", 0, out_w[0], 0);
        tick();
        check_eq("idle_abort_end", 0, rfd_w[0], 1);
`endif

        // Random trains with occasional cancellation.
        for (int it = 0; it < 60; it++) begin
            int d;
            int n;
            int total;
            int cut_at;
            int kind;
            d      = $urandom_range(0, 2);
            n      = $urandom_range(0, (1 << nw(d)) - 1);
            total  = (n + 1) * (hc(d) + lc(d));
            cut_at = -1;
            kind   = 0;
            if ($urandom_range(0, 5) == 0) begin
                cut_at = $urandom_range(1, total);
`ifdef PTG_ABORT_EN
                kind = $urandom_range(0, 2);
`endif
            end
            run_train(d, n, $urandom_range(1, 4), cut_at, kind);
            idle_cycles(d, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
